// File: rtl/nfu_pkg.sv
// nfu_pkg: shared defaults, control bundle and slicing helpers
// for the NFU accumulation stage.
package nfu_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_TN        = 16;
  localparam int DEF_LOG2_TN   = 4;
  localparam int DEF_ACC_WIDTH = 28;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } ctl_t;

  function automatic int lane_base(
    input int n,
    input int tn,
    input int bw
  );
    return n * tn * bw;
  endfunction

  function automatic int elem_base(
    input int n,
    input int i,
    input int tn,
    input int bw
  );
    return (n * tn + i) * bw;
  endfunction

endpackage

// File: rtl/nfu_2_adder_tree.sv
// nfu_2_adder_tree: one lane, registered leaves then LOG2_Tn
// registered pairwise-add levels held in heap order.
module nfu_2_adder_tree
  import nfu_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int Tn        = DEF_TN,
  parameter int LOG2_Tn   = DEF_LOG2_TN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BIT_WIDTH*Tn-1:0]           products,
  output logic signed [BIT_WIDTH+LOG2_Tn-1:0] sum
);

  localparam int TW = BIT_WIDTH + LOG2_Tn;

  // node[Tn..2Tn-1] are leaves, node[i] = node[2i] + node[2i+1]
  logic signed [TW-1:0] node [1:2*Tn-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 2 * Tn; i++)
        node[i] <= '0;
    end else begin
      for (int i = 0; i < Tn; i++)
        node[Tn+i] <= TW'(signed'(
          products[elem_base(0, i, Tn, BIT_WIDTH) +: BIT_WIDTH]));
      for (int i = 1; i < Tn; i++)
        node[i] <= node[2*i] + node[2*i+1];
    end
  end

  assign sum = node[1];

endmodule

// File: rtl/nfu_2_accum.sv
// nfu_2_accum: NFU stage 2, per-lane adder trees feeding
// first/last bracketed accumulators with saturated outputs.
module nfu_2_accum
  import nfu_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int Tn        = DEF_TN,
  parameter int TnxTn     = Tn * Tn,
  parameter int LOG2_Tn   = DEF_LOG2_TN,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic                       i_first,
  input  logic                       i_last,
  input  logic [BIT_WIDTH*TnxTn-1:0] i_products,
  output logic                       o_valid,
  output logic [BIT_WIDTH*Tn-1:0]    o_sums,
  output logic                       o_seq_err
);

  localparam int DEPTH = LOG2_Tn + 1;
  localparam int TW    = BIT_WIDTH + LOG2_Tn;

  ctl_t                        pipe [DEPTH];
  ctl_t                        tail;
  logic                        open;
  logic                        restart;
  logic signed [TW-1:0]        tree [Tn];
  logic signed [ACC_WIDTH-1:0] acc  [Tn];
  logic signed [ACC_WIDTH-1:0] nxt  [Tn];
  logic signed [BIT_WIDTH-1:0] res  [Tn];

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [ACC_WIDTH:0] v
  );
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1])
      return {v[ACC_WIDTH], {(ACC_WIDTH-1){~v[ACC_WIDTH]}}};
    return v[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] sat_bw(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic [ACC_WIDTH-BIT_WIDTH:0] top;
    top = v[ACC_WIDTH-1:BIT_WIDTH-1];
    if (&top || ~|top)
      return v[BIT_WIDTH-1:0];
    return {v[ACC_WIDTH-1], {(BIT_WIDTH-1){~v[ACC_WIDTH-1]}}};
  endfunction

  for (genvar n = 0; n < Tn; n++) begin : g_lane
    nfu_2_adder_tree #(
      .BIT_WIDTH (BIT_WIDTH),
      .Tn        (Tn),
      .LOG2_Tn   (LOG2_Tn)
    ) u_tree (
      .clk      (clk),
      .rst      (rst),
      .products (i_products[lane_base(n, Tn, BIT_WIDTH) +: Tn*BIT_WIDTH]),
      .sum      (tree[n])
    );
  end

  assign tail    = pipe[DEPTH-1];
  // a beat arriving while idle is handled as a first, even without the flag
  assign restart = !open || tail.first;

  always_comb begin
    for (int n = 0; n < Tn; n++) begin
      nxt[n] = restart
        ? ACC_WIDTH'(tree[n])
        : sat_acc((ACC_WIDTH+1)'(acc[n]) + (ACC_WIDTH+1)'(tree[n]));
      res[n] = sat_bw(nxt[n]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        pipe[k] <= '0;
      for (int n = 0; n < Tn; n++)
        acc[n] <= '0;
      open      <= 1'b0;
      o_valid   <= 1'b0;
      o_seq_err <= 1'b0;
      o_sums    <= '0;
    end else begin
      pipe[0] <= '{
        valid: i_valid,
        first: i_valid & i_first,
        last:  i_valid & i_last
      };
      for (int k = 1; k < DEPTH; k++)
        pipe[k] <= pipe[k-1];
      o_valid   <= 1'b0;
      o_seq_err <= 1'b0;
      if (tail.valid) begin
        o_seq_err <= (open == tail.first);
        open      <= !tail.last;
        for (int n = 0; n < Tn; n++)
          acc[n] <= nxt[n];
        if (tail.last) begin
          o_valid <= 1'b1;
          for (int n = 0; n < Tn; n++)
            o_sums[n*BIT_WIDTH +: BIT_WIDTH] <= res[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_nfu_2_accum.sv
// tb_nfu_2_accum: directed and random beats against a
// cycle-scheduled behavioural model of the accumulation rules.
module tb_nfu_2_accum;

  localparam int BW   = 16;
  localparam int TN   = 16;
  localparam int LG   = 4;
  localparam int AW   = 28;
  localparam int LAT  = LG + 1;
  localparam int MAXC = 4096;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid;
  logic                   i_first;
  logic                   i_last;
  logic [BW*TN*TN-1:0]    i_products;
  logic                   o_valid;
  logic [BW*TN-1:0]       o_sums;
  logic                   o_seq_err;

  always #5 clk = ~clk;

  nfu_2_accum #(
    .BIT_WIDTH (BW),
    .Tn        (TN),
    .TnxTn     (TN*TN),
    .LOG2_Tn   (LG),
    .ACC_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_first    (i_first),
    .i_last     (i_last),
    .i_products (i_products),
    .o_valid    (o_valid),
    .o_sums     (o_sums),
    .o_seq_err  (o_seq_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int             prod  [TN][TN];
  bit             ev    [MAXC];
  bit             ee    [MAXC];
  logic [BW*TN-1:0] es  [MAXC];
  logic [BW*TN-1:0] held;
  bit             m_open;
  longint         m_acc [TN];

  task automatic check(
    input string          tag,
    input logic [BW*TN-1:0] got,
    input logic [BW*TN-1:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // apply one valid beat, sampled at edge e, to the model
  task automatic model_beat(input bit f, input bit l, input int e);
    int     t;
    bit     restart;
    longint s;
    t = e + LAT;
    if (t >= MAXC) begin
      $display("FAIL schedule cyc=%0d limit=%0d", t, MAXC);
      $fatal(1);
    end
    restart = !m_open || f;
    ee[t] = (!m_open && !f) || (m_open && f);
    for (int n = 0; n < TN; n++) begin
      s = 0;
      for (int i = 0; i < TN; i++)
        s += prod[n][i];
      m_acc[n] = restart ? s : clamp(m_acc[n] + s, AW);
    end
    if (l) begin
      ev[t] = 1'b1;
      for (int n = 0; n < TN; n++)
        es[t][n*BW +: BW] = BW'(clamp(m_acc[n], BW));
    end
    m_open = !l;
  endtask

  task automatic verify();
    if (ev[cyc]) held = es[cyc];
    check("valid", {255'd0, o_valid}, {255'd0, ev[cyc]});
    check("seq_err", {255'd0, o_seq_err}, {255'd0, ee[cyc]});
    check("sums", o_sums, held);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    verify();
  endtask

  task automatic beat(input bit v, input bit f, input bit l);
    i_valid = v;
    i_first = f;
    i_last  = l;
    for (int n = 0; n < TN; n++)
      for (int i = 0; i < TN; i++)
        i_products[(n*TN+i)*BW +: BW] = BW'(prod[n][i]);
    if (v) model_beat(f, l, cyc + 1);
    tick();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++)
      beat(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic fill(input int v);
    for (int n = 0; n < TN; n++)
      for (int i = 0; i < TN; i++)
        prod[n][i] = v;
  endtask

  task automatic fill_lane();
    for (int n = 0; n < TN; n++)
      for (int i = 0; i < TN; i++)
        prod[n][i] = n;
  endtask

  task automatic fill_rand(input bit full);
    for (int n = 0; n < TN; n++)
      for (int i = 0; i < TN; i++)
        prod[n][i] = full ? int'($urandom_range(0, 65535)) - 32768
                          : int'($urandom_range(0, 200)) - 100;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {255'd0, o_valid}, '0);
    check("rst_err", {255'd0, o_seq_err}, '0);
    check("rst_sums", o_sums, '0);
    m_open = 1'b0;
    held   = '0;
    for (int c = cyc + 1; c < MAXC; c++) begin
      ev[c] = 1'b0;
      ee[c] = 1'b0;
    end
    i_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit v;
    bit f;
    bit l;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_first    = 1'b0;
    i_last     = 1'b0;
    i_products = '0;
    held       = '0;
    m_open     = 1'b0;
    for (int c = 0; c < MAXC; c++) es[c] = '0;
    for (int n = 0; n < TN; n++) m_acc[n] = 0;
    fill(0);
    tick();
    tick();
    rst = 1'b0;
    idle(2);

    // single pass
    fill(1);
    beat(1, 1, 1);
    idle(LAT + 1);

    // three passes with a bubble
    fill_lane();
    beat(1, 1, 0);
    beat(1, 0, 0);
    beat(0, 1, 1);
    beat(1, 0, 1);
    idle(LAT + 1);

    // output saturation both ways
    fill(32767);
    beat(1, 1, 0);
    beat(1, 0, 1);
    fill(-32768);
    beat(1, 1, 1);
    idle(LAT + 1);

    // protocol errors
    fill(3);
    beat(1, 0, 1);
    idle(LAT + 1);
    fill(5);
    beat(1, 1, 0);
    fill(7);
    beat(1, 1, 1);
    idle(LAT + 1);

    // reset mid-run with beats in flight
    fill(1);
    beat(1, 1, 0);
    beat(1, 0, 0);
    async_reset();
    fill(2);
    beat(1, 1, 1);
    idle(LAT + 1);

    // back-to-back runs
    fill(1);
    beat(1, 1, 0);
    beat(1, 0, 1);
    fill(-1);
    beat(1, 1, 1);
    idle(LAT + 1);

    // accumulator saturation then recovery
    fill(32767);
    beat(1, 1, 0);
    for (int j = 0; j < 299; j++) beat(1, 0, 0);
    fill(-32768);
    for (int j = 0; j < 256; j++) beat(1, 0, 0);
    fill(0);
    beat(1, 0, 1);
    idle(LAT + 1);

    // random traffic
    for (int j = 0; j < 500; j++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) < 3);
      l = ($urandom_range(0, 9) < 3);
      fill_rand(1'($urandom_range(0, 1)));
      beat(v, f, l);
    end
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
